// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle control FSM for the RV32I-subset datapath.
// Sequences FETCH/DECODE/EXECUTE/MEM/WB and drives the ALU control code,
// datapath enables and mux selects.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   op, funct3, funct7b5     latched instruction fields
//   zero                     ALU zero flag (used by BRANCH)
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   enables / address select
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl datapath selects
//   illegal                  illegal-opcode flag
//
// Optional feature macro: MC_ILLEGAL_TRAP_EN
//   defined   -> unknown opcode in DECODE enters HALT (illegal=1 until rst)
//   undefined -> unknown opcode in DECODE returns to FETCH, illegal tied 0
//
// Outputs are Moore-decoded from the state register; BRANCH additionally
// uses zero/funct3 for PCWrite, and rst gates every write enable.
module mc_control_unit #(
  parameter int unsigned OPW = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] op,
  input  logic [2:0]     funct3,
  input  logic           funct7b5,
  input  logic           zero,
  output logic           PCWrite,
  output logic           AdrSrc,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           RegWrite,
  output logic [1:0]     ResultSrc,
  output logic [1:0]     ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [2:0]     ImmSrc,
  output logic [2:0]     ALUControl,
  output logic           illegal
);

  localparam logic [OPW-1:0] OP_LW  = OPW'(7'b0000011);
  localparam logic [OPW-1:0] OP_SW  = OPW'(7'b0100011);
  localparam logic [OPW-1:0] OP_R   = OPW'(7'b0110011);
  localparam logic [OPW-1:0] OP_I   = OPW'(7'b0010011);
  localparam logic [OPW-1:0] OP_B   = OPW'(7'b1100011);
  localparam logic [OPW-1:0] OP_JAL = OPW'(7'b1101111);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL
`ifdef MC_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

  state_t     state, state_next;
  logic [2:0] alu_funct;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        if (op == OP_LW || op == OP_SW) state_next = S_MEMADR;
        else if (op == OP_R)            state_next = S_EXECR;
        else if (op == OP_I)            state_next = S_EXECI;
        else if (op == OP_B)            state_next = S_BRANCH;
        else if (op == OP_JAL)          state_next = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
        else                            state_next = S_HALT;
`else
        else                            state_next = S_FETCH;
`endif
      end
      S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = S_MEMWB;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_JAL:      state_next = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
      S_HALT:     state_next = S_HALT;
`endif
      default:    state_next = S_FETCH;
    endcase
  end

  // ALU operation selected by funct3 (sub only for R-type with funct7b5)
  always_comb begin
    alu_funct = ALU_ADD;
    case (funct3)
      3'b000:  alu_funct = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_funct = ALU_SLT;
      3'b100:  alu_funct = ALU_XOR;
      3'b110:  alu_funct = ALU_OR;
      3'b111:  alu_funct = ALU_AND;
      default: alu_funct = ALU_ADD;
    endcase
  end

  // Output decode; rst forces all write enables and illegal low
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    illegal    = 1'b0;

    if      (op == OP_SW)  ImmSrc = 3'b001;
    else if (op == OP_B)   ImmSrc = 3'b010;
    else if (op == OP_JAL) ImmSrc = 3'b011;
    else                   ImmSrc = 3'b000;

    case (state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_funct;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_funct;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        // beq/bne only; other funct3 encodings never redirect the PC
        PCWrite    = (funct3[2:1] == 2'b00) & (zero ^ funct3[0]);
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_HALT:     illegal = 1'b1;
`endif
      default: ;
    endcase

    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule
